sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised single-clock FIFO: next generation of the team's FIFO family for paths where producer and consumer share one clock. It adds selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow flags. It drops in wherever a same-clock buffer is needed between pipeline stages, and uses the same write/read port naming as the dual-clock FIFO.

## Interface
- DATA_SIZE, 8, word width in bits
- ADDR_SIZE, 4, address width; depth DEPTH = 2^ADDR_SIZE words
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AFULL_LVL, DEPTH-2, wr_afull asserted when count >= AFULL_LVL (legal 1..DEPTH)
- AEMPTY_LVL, 2, rd_aempty asserted when count <= AEMPTY_LVL (legal 0..DEPTH-1)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- wr_inc  in  1  write request
- wr_data  in  DATA_SIZE  write word
- wr_full  out  1  FIFO holds DEPTH words
- wr_afull  out  1  almost full
- rd_inc  in  1  read request
- rd_data  out  DATA_SIZE  read word
- rd_valid  out  1  standard mode: rd_data carries a freshly read word; FWFT: equals !rd_empty
- rd_empty  out  1  FIFO holds 0 words
- rd_aempty  out  1  almost empty
- count  out  ADDR_SIZE+1  occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read was rejected

## Operation
- Storage: DEPTH x DATA_SIZE register array. wr_ptr and rd_ptr are ADDR_SIZE+1 bit binary counters that wrap modulo 2^(ADDR_SIZE+1). The low ADDR_SIZE bits address the array.
- Empty: pointers equal. Full: MSBs differ and low bits equal. count = wr_ptr - rd_ptr, modulo 2^(ADDR_SIZE+1).
- rd_acc = rd_inc & !rd_empty.
- wr_acc = wr_inc & (!wr_full | rd_acc). A write to a full FIFO is accepted when a read is accepted in the same cycle.
- On wr_acc: mem[wr_ptr] <= wr_data; wr_ptr++.
- On rd_acc: rd_ptr++.
- Simultaneous accepted read and write: count unchanged.
- Simultaneous read and write while empty: the write is accepted and the read is rejected. Underflow is set.
- overflow set when wr_inc & !wr_acc. underflow set when rd_inc & rd_empty. Both hold until rst.
- Rejected operations change no pointer, memory word, count or data output.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1; otherwise rd_valid <= 0.
  - rd_data holds its last value when no read is accepted.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr low bits] combinationally; this is the head word whenever rd_empty=0.
  - rd_inc acknowledges (pops) the displayed word.
  - rd_data is don't-care while empty.
- wr_full, rd_empty, wr_afull, rd_aempty and count are all registered. Each is computed from the next-state count, so each is valid in the cycle that follows the edge that changed the occupancy.

## Timing
- Reset (rst=1 at an edge):
  - pointers 0, count 0
  - wr_full 0, wr_afull 0, rd_empty 1, rd_aempty 1
  - rd_valid 0, rd_data 0, overflow 0, underflow 0
  - memory contents are not cleared
- rst overrides wr_inc and rd_inc in the same cycle; in-flight data is discarded.
- Write-to-read latency:
  - FWFT: a word written at edge N is on rd_data with rd_empty=0 after edge N.
  - Standard: rd_empty falls after edge N. rd_inc at edge N+1 gives rd_data/rd_valid after edge N+1.
- Standard-mode read latency is 1 cycle. Throughput is 1 write and 1 read per cycle, sustained.
- Pointer wrap (past 2^(ADDR_SIZE+1)-1) is seamless: no bubble and no false flag.

## Test plan
- Reset, then DEPTH=16: write 0x00..0x0F on back-to-back cycles -> count 16, wr_full=1, wr_afull=1 from count 14. A 17th write is dropped and overflow=1.
- Standard mode: from full, read 16 on back-to-back cycles -> rd_data 0x00..0x0F, each one cycle after its rd_inc, rd_valid high 16 cycles. Then rd_empty=1 and rd_aempty=1 from count 2. An extra read gives underflow=1 and rd_valid=0.
- FWFT=1: write 0xA5 into an empty FIFO -> after that edge rd_empty=0 and rd_data=0xA5 with no rd_inc. rd_inc pops it and rd_empty=1 next cycle.
- Full plus simultaneous wr_inc/rd_inc for 40 cycles with incrementing data -> wr_full stays 1, count stays 16, no overflow, output order preserved across pointer wrap.
- Empty plus simultaneous wr_inc/rd_inc -> write accepted, count=1, underflow=1, rd_valid=0.
- Half-full FIFO with rst=1 asserted together with wr_inc and rd_inc -> next cycle count=0, rd_empty=1, all flags at reset values.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a standard or first-word-fall-through read port,
// registered status flags, occupancy count and sticky overflow/underflow.
module sync_fifo #(
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_SIZE  = 4,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = (1 << ADDR_SIZE) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_inc,
  input  logic [DATA_SIZE-1:0] wr_data,
  output logic                 wr_full,
  output logic                 wr_afull,
  input  logic                 rd_inc,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 rd_empty,
  output logic                 rd_aempty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int PW    = ADDR_SIZE + 1;

  localparam logic [ADDR_SIZE:0] FULL_CNT   = PW'(DEPTH);
  localparam logic [ADDR_SIZE:0] AFULL_CNT  = PW'(AFULL_LVL);
  localparam logic [ADDR_SIZE:0] AEMPTY_CNT = PW'(AEMPTY_LVL);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic [ADDR_SIZE:0]   wr_ptr, rd_ptr;
  logic [ADDR_SIZE:0]   wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 rd_acc, wr_acc;

  assign wr_addr = wr_ptr[ADDR_SIZE-1:0];
  assign rd_addr = rd_ptr[ADDR_SIZE-1:0];

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = rd_inc & ~rd_empty;
  assign wr_acc = wr_inc & (~wr_full | rd_acc);

  always_comb begin
    wr_ptr_nxt = wr_ptr + PW'(wr_acc);
    rd_ptr_nxt = rd_ptr + PW'(rd_acc);
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Flags are derived from the next-state count so they are registered yet
  // line up with the edge that changes occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_full   <= 1'b0;
      wr_afull  <= 1'b0;
      rd_empty  <= 1'b1;
      rd_aempty <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      wr_full   <= (count_nxt == FULL_CNT);
      wr_afull  <= (count_nxt >= AFULL_CNT);
      rd_empty  <= (count_nxt == '0);
      rd_aempty <= (count_nxt <= AEMPTY_CNT);
      overflow  <= overflow  | (wr_inc & ~wr_acc);
      underflow <= underflow | (rd_inc & rd_empty);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_addr] <= wr_data;
    end
  end

  if (FWFT == 0) begin : g_std
    logic [DATA_SIZE-1:0] data_q;
    logic                 valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) begin
          data_q <= mem[rd_addr];
        end
      end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;
  end else begin : g_fwft
    // Head word is shown directly; rd_inc acknowledges it.
    assign rd_data  = mem[rd_addr];
    assign rd_valid = ~rd_empty;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-mode instance and an FWFT instance
// sharing clock and reset.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;

  logic       wr_inc, rd_inc;
  logic [7:0] wr_data;
  logic       wr_full, wr_afull, rd_valid, rd_empty, rd_aempty, overflow, underflow;
  logic [7:0] rd_data;
  logic [4:0] count;

  logic       f_wr_inc, f_rd_inc;
  logic [7:0] f_wr_data;
  logic       f_wr_full, f_wr_afull, f_rd_valid, f_rd_empty, f_rd_aempty, f_overflow, f_underflow;
  logic [7:0] f_rd_data;
  logic [4:0] f_count;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_SIZE(8), .ADDR_SIZE(4), .FWFT(0), .AFULL_LVL(14), .AEMPTY_LVL(2)) u_std (
    .clk(clk), .rst(rst),
    .wr_inc(wr_inc), .wr_data(wr_data), .wr_full(wr_full), .wr_afull(wr_afull),
    .rd_inc(rd_inc), .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
    .rd_aempty(rd_aempty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo #(.DATA_SIZE(8), .ADDR_SIZE(4), .FWFT(1), .AFULL_LVL(14), .AEMPTY_LVL(2)) u_fwft (
    .clk(clk), .rst(rst),
    .wr_inc(f_wr_inc), .wr_data(f_wr_data), .wr_full(f_wr_full), .wr_afull(f_wr_afull),
    .rd_inc(f_rd_inc), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .rd_empty(f_rd_empty),
    .rd_aempty(f_rd_aempty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(wr_full), 0);
    chk("rst_afull", 32'(wr_afull), 0);
    chk("rst_empty", 32'(rd_empty), 1);
    chk("rst_aempty", 32'(rd_aempty), 1);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
  endtask

  initial begin
    rst = 1'b1;
    wr_inc = 1'b0; rd_inc = 1'b0; wr_data = '0;
    f_wr_inc = 1'b0; f_rd_inc = 1'b0; f_wr_data = '0;
    #1;
    tick();
    tick();
    rst = 1'b0;
    chk_reset_state();
    chk("f_rst_empty", 32'(f_rd_empty), 1);
    chk("f_rst_valid", 32'(f_rd_valid), 0);

    // Fill with 0x00..0x0F back to back
    for (int i = 0; i < 16; i++) begin
      wr_inc = 1'b1; wr_data = 8'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(wr_afull), (i + 1 >= 14) ? 1 : 0);
      chk("fill_aempty", 32'(rd_aempty), (i + 1 <= 2) ? 1 : 0);
      chk("fill_empty", 32'(rd_empty), 0);
      chk("fill_full", 32'(wr_full), (i == 15) ? 1 : 0);
    end
    chk("fill_ovf", 32'(overflow), 0);

    // 17th write is dropped
    wr_data = 8'h10;
    tick();
    wr_inc = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_full", 32'(wr_full), 1);

    // Drain 16 words, each shown one cycle after its rd_inc
    for (int k = 0; k < 16; k++) begin
      rd_inc = 1'b1;
      tick();
      chk("drain_data", 32'(rd_data), 32'(k));
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_count", 32'(count), 32'(15 - k));
      chk("drain_aempty", 32'(rd_aempty), (15 - k <= 2) ? 1 : 0);
      chk("drain_empty", 32'(rd_empty), (k == 15) ? 1 : 0);
      chk("drain_full", 32'(wr_full), 0);
    end

    // Extra read on empty
    tick();
    rd_inc = 1'b0;
    chk("unf_set", 32'(underflow), 1);
    chk("unf_valid", 32'(rd_valid), 0);
    chk("unf_data_hold", 32'(rd_data), 32'h0F);
    chk("unf_count", 32'(count), 0);
    tick();
    chk("idle_valid", 32'(rd_valid), 0);

    // FWFT: single word falls through without rd_inc
    f_wr_inc = 1'b1; f_wr_data = 8'hA5;
    tick();
    f_wr_inc = 1'b0;
    chk("f_empty_fall", 32'(f_rd_empty), 0);
    chk("f_data", 32'(f_rd_data), 32'hA5);
    chk("f_valid", 32'(f_rd_valid), 1);
    chk("f_count1", 32'(f_count), 1);
    tick();
    chk("f_data_hold", 32'(f_rd_data), 32'hA5);
    f_rd_inc = 1'b1;
    tick();
    f_rd_inc = 1'b0;
    chk("f_pop_empty", 32'(f_rd_empty), 1);
    chk("f_pop_valid", 32'(f_rd_valid), 0);
    chk("f_pop_count", 32'(f_count), 0);
    f_wr_inc = 1'b1; f_wr_data = 8'h11;
    tick();
    f_wr_data = 8'h22;
    tick();
    f_wr_inc = 1'b0;
    chk("f_head1", 32'(f_rd_data), 32'h11);
    f_rd_inc = 1'b1;
    tick();
    f_rd_inc = 1'b0;
    chk("f_head2", 32'(f_rd_data), 32'h22);
    chk("f_unf", 32'(f_underflow), 0);

    // Full + simultaneous read/write across pointer wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state();
    for (int i = 0; i < 16; i++) begin
      wr_inc = 1'b1; wr_data = 8'(i);
      tick();
    end
    chk("pre_full", 32'(wr_full), 1);
    rd_inc = 1'b1;
    for (int j = 0; j < 40; j++) begin
      wr_data = 8'(16 + j);
      tick();
      chk("sim_data", 32'(rd_data), 32'(j));
      chk("sim_valid", 32'(rd_valid), 1);
      chk("sim_count", 32'(count), 16);
      chk("sim_full", 32'(wr_full), 1);
    end
    wr_inc = 1'b0; rd_inc = 1'b0;
    chk("sim_ovf", 32'(overflow), 0);
    chk("sim_unf", 32'(underflow), 0);

    // Empty + simultaneous read/write
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state();
    wr_inc = 1'b1; rd_inc = 1'b1; wr_data = 8'h77;
    tick();
    wr_inc = 1'b0; rd_inc = 1'b0;
    chk("ew_count", 32'(count), 1);
    chk("ew_unf", 32'(underflow), 1);
    chk("ew_valid", 32'(rd_valid), 0);
    chk("ew_empty", 32'(rd_empty), 0);
    chk("ew_data", 32'(rd_data), 0);
    chk("ew_ovf", 32'(overflow), 0);
    rd_inc = 1'b1;
    tick();
    rd_inc = 1'b0;
    chk("ew_read", 32'(rd_data), 32'h77);
    chk("ew_read_valid", 32'(rd_valid), 1);

    // Half full, then reset with wr_inc/rd_inc asserted
    for (int i = 0; i < 8; i++) begin
      wr_inc = 1'b1; wr_data = 8'(8'h40 + i);
      tick();
    end
    chk("half_count", 32'(count), 8);
    rd_inc = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; wr_inc = 1'b0; rd_inc = 1'b0;
    chk_reset_state();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
